// File: rtl/ks_split_16bit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ks_pkg
// Brief    : Shared constants, tag encoding and FSM state type for the GF(2)
//            Karatsuba operand splitter and its combiner-side collector.
// Revision : 1.0 - initial release
// ============================================================================
package ks_pkg;

  localparam int HALF_W = 8;
  localparam int TAG_W  = 2;
  localparam int ID_W   = 4;

  // Tags map onto the combiner inputs: LO -> z0, HI -> z2, MID -> z1.
  localparam logic [TAG_W-1:0] TAG_LO  = 2'd0;
  localparam logic [TAG_W-1:0] TAG_HI  = 2'd1;
  localparam logic [TAG_W-1:0] TAG_MID = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_MID  = 2'd3
  } state_t;

endpackage : ks_pkg
`default_nettype wire

// File: rtl/ks_split_16bit_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ks_split_16bit_seq_if
// Brief    : Request channel and sub-job channel of the Karatsuba splitter.
//            slave = splitter view, master = requester/multiplier view.
// Revision : 1.0 - initial release
// ============================================================================
interface ks_split_16bit_seq_if
  import ks_pkg::*;
#(
  parameter int HALF_W = ks_pkg::HALF_W,
  parameter int TAG_W  = ks_pkg::TAG_W
);
  // Request side
  logic                  in_valid;
  logic                  in_ready;
  logic [2*HALF_W-1:0]   in_a;
  logic [2*HALF_W-1:0]   in_b;
  logic [ID_W-1:0]       in_id;
  // Sub-job side
  logic                  job_valid;
  logic                  job_ready;
  logic [HALF_W-1:0]     job_a;
  logic [HALF_W-1:0]     job_b;
  logic [TAG_W-1:0]      job_tag;
  logic [ID_W-1:0]       job_id;
  logic                  job_last;

  modport slave (
    input  in_valid, in_a, in_b, in_id, job_ready,
    output in_ready, job_valid, job_a, job_b, job_tag, job_id, job_last
  );

  modport master (
    output in_valid, in_a, in_b, in_id, job_ready,
    input  in_ready, job_valid, job_a, job_b, job_tag, job_id, job_last
  );

endinterface : ks_split_16bit_seq_if
`default_nettype wire

// File: rtl/ks_split_16bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : ks_split_16bit_seq
// Brief    : Splits one 16x16 carry-less multiply into LO, HI and MID 8x8
//            sub-jobs issued in that order over a valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
module ks_split_16bit_seq
  import ks_pkg::*;
(
  input  wire                    clk,
  input  wire                    rst,
  ks_split_16bit_seq_if.slave    bus
);

  localparam int c_OP_W = 2 * HALF_W;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_in_ready;
  logic                  w_capture;

  logic [c_OP_W-1:0]     r_a;
  logic [c_OP_W-1:0]     r_b;
  logic [ID_W-1:0]       r_id;
  logic [c_OP_W-1:0]     w_a_nxt;
  logic [c_OP_W-1:0]     w_b_nxt;
  logic [ID_W-1:0]       w_id_nxt;

  logic                  r_job_valid;
  logic [HALF_W-1:0]     r_job_a;
  logic [HALF_W-1:0]     r_job_b;
  logic [TAG_W-1:0]      r_job_tag;
  logic [ID_W-1:0]       r_job_id;
  logic                  r_job_last;
  logic                  w_job_valid;
  logic [HALF_W-1:0]     w_job_a;
  logic [HALF_W-1:0]     w_job_b;
  logic [TAG_W-1:0]      w_job_tag;
  logic                  w_job_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, request acceptance, and next values of the registered job
  // outputs (derived from next state and next captured operands so the job
  // fields line up with the state they describe).
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LO;
        end
      end
      ST_LO:  if (bus.job_ready) w_state_nxt = ST_HI;
      ST_HI:  if (bus.job_ready) w_state_nxt = ST_MID;
      ST_MID: begin
        if (bus.job_ready) begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_LO;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_a_nxt  = w_capture ? bus.in_a  : r_a;
    w_b_nxt  = w_capture ? bus.in_b  : r_b;
    w_id_nxt = w_capture ? bus.in_id : r_id;

    w_job_valid = 1'b0;
    w_job_a     = '0;
    w_job_b     = '0;
    w_job_tag   = TAG_LO;
    w_job_last  = 1'b0;
    unique case (w_state_nxt)
      ST_LO: begin
        w_job_valid = 1'b1;
        w_job_a     = w_a_nxt[HALF_W-1:0];
        w_job_b     = w_b_nxt[HALF_W-1:0];
        w_job_tag   = TAG_LO;
      end
      ST_HI: begin
        w_job_valid = 1'b1;
        w_job_a     = w_a_nxt[c_OP_W-1:HALF_W];
        w_job_b     = w_b_nxt[c_OP_W-1:HALF_W];
        w_job_tag   = TAG_HI;
      end
      ST_MID: begin
        w_job_valid = 1'b1;
        w_job_a     = w_a_nxt[HALF_W-1:0] ^ w_a_nxt[c_OP_W-1:HALF_W];
        w_job_b     = w_b_nxt[HALF_W-1:0] ^ w_b_nxt[c_OP_W-1:HALF_W];
        w_job_tag   = TAG_MID;
        w_job_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand capture and registered job outputs; the id is only shown while
  // a job is valid so idle outputs match the reset values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_job_valid <= 1'b0;
      r_job_a     <= '0;
      r_job_b     <= '0;
      r_job_tag   <= '0;
      r_job_id    <= '0;
      r_job_last  <= 1'b0;
    end else begin
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_id        <= w_id_nxt;
      r_job_valid <= w_job_valid;
      r_job_a     <= w_job_a;
      r_job_b     <= w_job_b;
      r_job_tag   <= w_job_tag;
      r_job_id    <= w_job_valid ? w_id_nxt : '0;
      r_job_last  <= w_job_last;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.job_valid = r_job_valid;
  assign bus.job_a     = r_job_a;
  assign bus.job_b     = r_job_b;
  assign bus.job_tag   = r_job_tag;
  assign bus.job_id    = r_job_id;
  assign bus.job_last  = r_job_last;

endmodule : ks_split_16bit_seq
`default_nettype wire

// File: tb/tb_ks_split_16bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ks_split_16bit_seq
// Brief    : Directed self-checking bench for the Karatsuba operand splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ks_split_16bit_seq;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  ks_split_16bit_seq_if bus ();

  ks_split_16bit_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a valid job: {a, b, tag, id, last} packed into one word.
  task automatic exp_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] t, input logic [3:0] id, input logic last);
    chk({tag, ".valid"}, {31'd0, bus.job_valid}, 32'd1);
    chk({tag, ".fields"},
        {9'd0, bus.job_a, bus.job_b, bus.job_tag, bus.job_id, bus.job_last},
        {9'd0, a, b, t, id, last});
  endtask

  task automatic present(input logic [15:0] a, input logic [15:0] b, input logic [3:0] id);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_id    = id;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_id     = '0;
    bus.job_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst.outputs",
        {8'd0, bus.job_valid, bus.job_a, bus.job_b, bus.job_tag, bus.job_id, bus.job_last},
        32'd0);

    // Single request, job_ready held high
    bus.job_ready = 1'b1;
    present(16'hA53C, 16'h0F81, 4'd3);
    chk("s1.accept_rdy", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    exp_job("s1.lo", 8'h3C, 8'h81, 2'd0, 4'd3, 1'b0);
    chk("s1.lo_busy", {31'd0, bus.in_ready}, 32'd0);
    step();
    exp_job("s1.hi", 8'hA5, 8'h0F, 2'd1, 4'd3, 1'b0);
    step();
    exp_job("s1.mid", 8'h99, 8'h8E, 2'd2, 4'd3, 1'b1);
    chk("s1.mid_rdy", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("s1.idle", {31'd0, bus.job_valid}, 32'd0);

    // Backpressure for 4 cycles while in HI
    present(16'hA53C, 16'h0F81, 4'd3);
    step();
    bus.in_valid = 1'b0;
    exp_job("bp.lo", 8'h3C, 8'h81, 2'd0, 4'd3, 1'b0);
    step();
    bus.job_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_job("bp.hold", 8'hA5, 8'h0F, 2'd1, 4'd3, 1'b0);
      chk("bp.hold_rdy", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    exp_job("bp.hold_last", 8'hA5, 8'h0F, 2'd1, 4'd3, 1'b0);
    bus.job_ready = 1'b1;
    step();
    exp_job("bp.mid", 8'h99, 8'h8E, 2'd2, 4'd3, 1'b1);
    step();
    chk("bp.idle", {31'd0, bus.job_valid}, 32'd0);

    // Back-to-back requests
    present(16'hFFFF, 16'h0001, 4'd1);
    step();
    present(16'h1234, 16'h5678, 4'd2);
    exp_job("b2b.r1lo", 8'hFF, 8'h01, 2'd0, 4'd1, 1'b0);
    chk("b2b.r1lo_rdy", {31'd0, bus.in_ready}, 32'd0);
    step();
    exp_job("b2b.r1hi", 8'hFF, 8'h00, 2'd1, 4'd1, 1'b0);
    step();
    exp_job("b2b.r1mid", 8'h00, 8'h01, 2'd2, 4'd1, 1'b1);
    chk("b2b.r1mid_rdy", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    exp_job("b2b.r2lo", 8'h34, 8'h78, 2'd0, 4'd2, 1'b0);
    step();
    exp_job("b2b.r2hi", 8'h12, 8'h56, 2'd1, 4'd2, 1'b0);
    step();
    exp_job("b2b.r2mid", 8'h26, 8'h2E, 2'd2, 4'd2, 1'b1);
    step();
    chk("b2b.idle", {31'd0, bus.job_valid}, 32'd0);

    // Busy rejection: competing request held during LO and HI
    present(16'h00FF, 16'hFF00, 4'd4);
    step();
    present(16'hBEEF, 16'hCAFE, 4'd7);
    exp_job("busy.lo", 8'hFF, 8'h00, 2'd0, 4'd4, 1'b0);
    chk("busy.lo_rdy", {31'd0, bus.in_ready}, 32'd0);
    step();
    exp_job("busy.hi", 8'h00, 8'hFF, 2'd1, 4'd4, 1'b0);
    chk("busy.hi_rdy", {31'd0, bus.in_ready}, 32'd0);
    step();
    bus.in_valid = 1'b0;
    exp_job("busy.mid", 8'hFF, 8'hFF, 2'd2, 4'd4, 1'b1);
    step();
    chk("busy.idle", {31'd0, bus.job_valid}, 32'd0);

    // Reset while in HI
    present(16'h1111, 16'h2222, 4'd6);
    step();
    bus.in_valid = 1'b0;
    exp_job("rmid.lo", 8'h11, 8'h22, 2'd0, 4'd6, 1'b0);
    step();
    exp_job("rmid.hi", 8'h11, 8'h22, 2'd1, 4'd6, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid.valid", {31'd0, bus.job_valid}, 32'd0);
    chk("rmid.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rmid.outputs",
        {9'd0, bus.job_a, bus.job_b, bus.job_tag, bus.job_id, bus.job_last}, 32'd0);
    step();
    chk("rmid.no_mid", {31'd0, bus.job_valid}, 32'd0);

    // Fresh request; operands change the cycle after acceptance
    present(16'h0102, 16'h0304, 4'd9);
    step();
    bus.in_valid = 1'b0;
    bus.in_a     = 16'hFFFF;
    bus.in_b     = 16'hFFFF;
    bus.in_id    = 4'hF;
    exp_job("chg.lo", 8'h02, 8'h04, 2'd0, 4'd9, 1'b0);
    step();
    exp_job("chg.hi", 8'h01, 8'h03, 2'd1, 4'd9, 1'b0);
    step();
    exp_job("chg.mid", 8'h03, 8'h07, 2'd2, 4'd9, 1'b1);
    step();
    chk("chg.idle", {31'd0, bus.job_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_ks_split_16bit_seq
`default_nettype wire

// File: doc/ks_split_16bit_seq.md
Name: ks_split_16bit_seq

Overview:
- Operand-side counterpart of the 16-bit overlap-sum combiner in the GF(2) Karatsuba datapath.
- Accepts one 16x16 carry-less multiply request and splits it into the three 8x8 sub-products the combiner consumes: low (feeds z0), high (feeds z2), middle (feeds z1).
- Issues the sub-products one per handshake to a shared 8x8 multiplier over a valid/ready channel, tagging each job.

Parameters:
- HALF_W, 8, half-operand width; the operand width is 2*HALF_W.
- TAG_W, 2, width of the job tag.

Ports:
- clk  input  1  clock; all logic rises on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_a  input  16  operand A (GF(2) polynomial, bit i = x^i).
- in_b  input  16  operand B.
- in_id  input  4  request identifier, echoed on every job.
- job_valid  output  1  sub-job valid.
- job_ready  input  1  downstream multiplier accepts the sub-job.
- job_a  output  8  sub-operand A.
- job_b  output  8  sub-operand B.
- job_tag  output  2  0 = LO, 1 = HI, 2 = MID; 3 is never driven.
- job_id  output  4  echoed in_id.
- job_last  output  1  high on the MID job only.

Behaviour:
- Reset values: in_ready=1, job_valid=0, job_a=0, job_b=0, job_tag=0, job_id=0, job_last=0. The FSM enters IDLE and the operand registers clear.
- FSM states: IDLE, LO, HI, MID.
- IDLE: in_ready=1. When in_valid&&in_ready, capture a, b and id, then go to LO on the next cycle.
- LO: job_valid=1, job_a=a[7:0], job_b=b[7:0], tag=0. On job_ready go to HI; otherwise hold.
- HI: job_a=a[15:8], job_b=b[15:8], tag=1. On job_ready go to MID.
- MID: job_a=a[7:0]^a[15:8], job_b=b[7:0]^b[15:8], tag=2, job_last=1.
- MID with job_ready: if in_valid, capture the new request and go to LO (back-to-back). Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==MID && job_ready). This combinational path from job_ready is permitted.
- All job_* outputs are registered. They are driven from the captured operands and the state, never directly from the in_* ports.
- Latency: request accepted at cycle N, LO valid at N+1. Minimum issue interval is 3 jobs per request; sustained throughput is one request per 3 cycles with job_ready held high.
- Backpressure: while job_valid=1 and job_ready=0, job_a, job_b, job_tag, job_id and job_last hold stable. job_valid never drops without a handshake.
- in_a and in_b may change after acceptance with no effect on in-flight jobs.
- Reset mid-operation: any in-flight job is discarded, no partial sequence resumes, and all outputs return to reset values in the next cycle.
- in_valid while busy (LO/HI, or MID without job_ready): in_ready=0 and the request is not captured. The upstream side holds it.
- Arithmetic: only bitwise XOR, no carries; widths are exact (8-bit results from 8-bit operands).

Decomposition:
- Shared package ks_pkg holds:
  - HALF_W and TAG_W constants.
  - Tag encoding constants TAG_LO=0, TAG_HI=1, TAG_MID=2, shared with the combiner-side collector so tags map to z0, z2 and z1 respectively.
  - The FSM state enum.
- No sub-module is needed. The operand XOR is inline and the block is a single FSM plus a capture register.

Test Plan:
- Single request: in_a=16'hA53C, in_b=16'h0F81, id=3, job_ready=1.
  - Jobs appear on consecutive cycles: (3C,81,tag0), (A5,0F,tag1), (99,8E,tag2,last=1).
  - All three carry id=3.
  - in_ready returns to 1 during the MID handshake.
- Backpressure: same request with job_ready=0 for 4 cycles during HI.
  - job_a=A5 and job_b=0F are held stable with job_valid=1.
  - MID follows one cycle after job_ready rises.
- Back-to-back: request 1 = (16'hFFFF,16'h0001,id 1), request 2 = (16'h1234,16'h5678,id 2), both presented continuously with job_ready=1.
  - Jobs for request 1 are (FF,01), (FF,00), (00,01).
  - Request 2 is accepted in the MID cycle of request 1, and its LO job (34,78) follows immediately with no gap.
- Busy rejection: in_valid asserted during LO and HI states.
  - in_ready=0 and no capture occurs.
  - Tags stay strictly ordered 0,1,2 per request.
- Reset mid-job: assert rst in HI state for 1 cycle.
  - Next cycle job_valid=0 and in_ready=1, with no MID job emitted.
  - A fresh request then starts at tag 0.
- Operand change after accept: modify in_a and in_b the cycle after acceptance.
  - Emitted jobs still reflect the captured values.
